// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, funct3 codes, request record.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W     = 32;
  // Request record carries a full-width address; the top uses only DM_ADDRESS bits.
  localparam int unsigned DMEM_ADDR_MAX_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_MAX_W-1:0] addr;
    logic [DMEM_DATA_W-1:0]     wdata;
    logic [2:0]                 funct3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering for RV32I loads/stores: write enables, aligned write word,
// sign/zero-extended load data and the misalignment/illegal-funct3 error.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal;
  logic        misalign;

  always_comb begin
    byte_sel = 8'(rword >> {lane, 3'b000});
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
    be       = 4'b0000;
    wword    = wdata;
    rdata    = '0;
    illegal  = 1'b0;
    misalign = 1'b0;

    case (funct3)
      F3_B, F3_BU: begin
        illegal = we && (funct3 == F3_BU);
        be      = 4'b0001 << lane;
        wword   = {4{wdata[7:0]}};
        rdata   = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      F3_H, F3_HU: begin
        illegal  = we && (funct3 == F3_HU);
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rdata    = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      F3_W: begin
        misalign = |lane;
        be       = 4'b1111;
        wword    = wdata;
        rdata    = rword;
      end
      default: illegal = 1'b1;
    endcase

    err = illegal | misalign;
    // Errors never write and never return data; stores return zero.
    if (err || !we) be = 4'b0000;
    if (err || we) rdata = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYCLES wait states,
// commit (write or read capture) on the edge that enters the response state.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned Words    = (1 << DM_ADDRESS) / 4;
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [DATA_W-1:0] mem [Words];

  dmem_state_e       state_q;
  logic [3:0]        cnt_q;
  dmem_req_t         req_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  dmem_req_t           in_req;
  dmem_req_t           cur_req;
  logic [DM_ADDRESS-3:0] word_idx;
  logic                commit;
  logic [DATA_W-1:0]   rword;
  logic [3:0]          fmt_be;
  logic [DATA_W-1:0]   fmt_wword;
  logic [DATA_W-1:0]   fmt_rdata;
  logic                fmt_err;
  logic                unused_addr_hi;

  always_comb begin
    in_req = '{we: req_we, addr: DMEM_ADDR_MAX_W'(req_addr), wdata: req_wdata,
               funct3: req_funct3};
    // With zero wait states the commit edge is the accept edge, so use the live request.
    cur_req  = (state_q == StIdle) ? in_req : req_q;
    word_idx = cur_req.addr[DM_ADDRESS-1:2];
    rword    = mem[word_idx];
    commit   = ((state_q == StIdle) && req_valid && (WAIT_CYCLES == 0)) ||
               ((state_q == StWait) && (cnt_q == 4'd0));
  end

  assign unused_addr_hi = ^cur_req.addr[DMEM_ADDR_MAX_W-1:DM_ADDRESS];

  dmem_lane_fmt u_lane_fmt (
    .we     (cur_req.we),
    .funct3 (cur_req.funct3),
    .lane   (cur_req.addr[1:0]),
    .rword  (rword),
    .wdata  (cur_req.wdata),
    .be     (fmt_be),
    .wword  (fmt_wword),
    .rdata  (fmt_rdata),
    .err    (fmt_err)
  );

  // Array is not reset; gating on reset keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (commit && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (fmt_be[b]) mem[word_idx][8*b +: 8] <= fmt_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_q <= in_req;
            if (WAIT_CYCLES == 0) begin
              state_q     <= StResp;
              rsp_rdata_q <= fmt_rdata;
              rsp_err_q   <= fmt_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q     <= StResp;
            rsp_rdata_q <= fmt_rdata;
            rsp_err_q   <= fmt_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses, monitor checks them.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_W      (32),
    .DM_ADDRESS  (9),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected {err, rdata}.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected response", {31'b0, rsp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[31:0]);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
        end
      end
    end
  end

  task automatic send(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3);
    int n;
    @(negedge clk);
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready before accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    check("return to idle", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
    exp_q.push_back({exp_err, exp_rdata});
    send(we, addr, wdata, f3);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b1;
    #12;
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Store then sign/zero-extended loads.
    issue(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    issue(1'b0, 9'h013, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 9'h013, 32'h0, 3'b100, 32'h000000DE, 1'b0);
    issue(1'b0, 9'h012, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 9'h010, 32'h0, 3'b101, 32'h0000BEEF, 1'b0);
    issue(1'b1, 9'h011, 32'h0000007F, 3'b000, 32'h0, 1'b0);
    issue(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD7FEF, 1'b0);

    // Misaligned accesses.
    issue(1'b1, 9'h020, 32'h11223344, 3'b010, 32'h0, 1'b0);
    issue(1'b1, 9'h014, 32'h55667788, 3'b010, 32'h0, 1'b0);
    issue(1'b0, 9'h022, 32'h0, 3'b010, 32'h0, 1'b1);
    issue(1'b1, 9'h015, 32'h0000FFFF, 3'b001, 32'h0, 1'b1);
    issue(1'b0, 9'h020, 32'h0, 3'b010, 32'h11223344, 1'b0);
    issue(1'b0, 9'h014, 32'h0, 3'b010, 32'h55667788, 1'b0);

    // Illegal funct3.
    issue(1'b0, 9'h010, 32'h0, 3'b011, 32'h0, 1'b1);
    issue(1'b1, 9'h010, 32'hFFFFFFFF, 3'b100, 32'h0, 1'b1);
    issue(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD7FEF, 1'b0);

    // Cycle-accurate timing with a stalled response.
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hDEAD7FEF});
    send(1'b0, 9'h010, 32'h0, 3'b010);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("cycle%0d rsp_valid", c), {31'b0, rsp_valid}, (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("cycle%0d req_ready", c), {31'b0, req_ready}, 32'd0);
      check($sformatf("cycle%0d busy", c), {31'b0, busy}, 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall rsp_rdata", rsp_rdata, 32'hDEAD7FEF);
      check("stall rsp_err", {31'b0, rsp_err}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post-rsp req_ready", {31'b0, req_ready}, 32'd1);
    check("post-rsp busy", {31'b0, busy}, 32'd0);
    check("post-rsp rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset during WAIT abandons the store.
    issue(1'b1, 9'h040, 32'hAAAAAAAA, 3'b010, 32'h0, 1'b0);
    send(1'b1, 9'h040, 32'h12345678, 3'b010);
    #2 reset = 1'b0;
    #1;
    check("midreset req_ready", {31'b0, req_ready}, 32'd1);
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midreset rsp_rdata", rsp_rdata, 32'd0);
    check("midreset rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 9'h040, 32'h0, 3'b010, 32'hAAAAAAAA, 1'b0);

    @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory request interface. It accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- It performs RV32I byte/half/word stores and sign- or zero-extended loads selected by funct3, then returns the result on a valid/ready response channel.
- It sits behind the MEM stage as a multi-cycle replacement for the single-cycle data memory and lets the core be exercised with memory stalls.

Parameters:
- DATA_W, 32, data width; only 32 is supported.
- DM_ADDRESS, 9, byte-address width; the array holds 2**DM_ADDRESS/4 words (128 at default).
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data; the relevant bytes are in the low lanes.
- req_funct3  in  3  RV32I width/sign code.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal funct3.
- busy  out  1  a request is in flight (state != IDLE).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While reset=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0. Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a clock edge, the responder latches we/addr/wdata/funct3 and computes the error.
  - If WAIT_CYCLES=0 it goes to RESP; otherwise it goes to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle. When counter=0, the next edge enters RESP.
- Commit edge: the edge that enters RESP.
  - A store writes its byte lanes on this edge.
  - A load captures its read data on this edge.
  - Without error, rsp_rdata is the formatted load data or 0 for a store, and rsp_err=0.
  - With error, rsp_rdata=0, rsp_err=1 and no write occurs.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable; req_ready=0.
  - On rsp_ready=1 the next edge returns to IDLE with rsp_valid=0.
  - No request is accepted in the same cycle as the response handshake; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Latency: a request accepted at edge N gives rsp_valid=1 during the cycle after edge N+WAIT_CYCLES. With WAIT=2, accept at cycle 0 gives response at cycle 3.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is an error.
- Alignment: halfword accesses require addr[0]=0 and word accesses require addr[1:0]=00; violations are errors.
- Memory organisation: little-endian byte lanes. Word index = addr[DM_ADDRESS-1:2]; lane = addr[1:0].
- Load formatting: LB/LH sign-extend bit 7/15 of the selected lane(s); LBU/LHU zero-extend.
- Store byte enables: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes.
- Reset mid-operation: a request in WAIT is abandoned and its store never commits. A pending response in RESP is dropped.
- req_valid while not in IDLE is ignored; the requester must hold the request until it sees req_ready.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a packed request struct (we, addr, wdata, funct3).
- One sub-module, dmem_lane_fmt, is combinational. It takes funct3, addr[1:0], the read word and wdata. It produces byte enables, the aligned write word, the formatted load data and the error flag.

Test Plan:
- SW 0xDEADBEEF @0x10, then LB @0x13 -> rdata=0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB wdata=0x0000007F @0x11, then LW @0x10 -> 0xDEAD7FEF, err=0.
- LW @0x22 and SH @0x15 -> err=1, rdata=0; a following LW of those words returns the previous contents unchanged.
- Timing with WAIT_CYCLES=2: req accepted at cycle 0 -> rsp_valid first high in cycle 3.
  - req_ready=0 and busy=1 in cycles 1-3.
  - Hold rsp_ready=0 for 3 more cycles -> rsp_valid, rdata and err remain stable.
  - After rsp_ready=1 -> IDLE, req_ready=1.
- funct3=011 load and funct3=100 store -> err=1, no memory change.
- Store SW 0x12345678 @0x40 over prior 0xAAAAAAAA; assert reset during WAIT -> all outputs at reset values immediately; LW @0x40 afterwards -> 0xAAAAAAAA.
